flit_buffer: RTL
================

# flit_buffer

Elastic flit FIFO between a `fabric` traffic node's output (`data_o`/`out_w`/`out_r`) and the next hop's input, either a router port or another node. It uses the same write/ready handshake on both sides. It decouples back-pressure and checks packet framing. Well-formed flits pass through in order. Orphan body/tail flits are discarded and flagged.

## Interface
Parameters:
- `DATA_SIZE`, 4, payload bits per flit; flit width is DATA_SIZE+2.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1, width of `count`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `a_rst`  in  1  asynchronous, active-high reset.
- `data_i`  in  DATA_SIZE+2  incoming flit.
- `in_w`  in  1  upstream has a valid flit on `data_i`.
- `in_r`  out  1  buffer can accept a flit this cycle.
- `data_o`  out  DATA_SIZE+2  head-of-FIFO flit.
- `out_w`  out  1  `data_o` valid.
- `out_r`  in  1  downstream accepts this cycle.
- `count`  out  CNT_W  number of stored flits.
- `err`  out  1  one-cycle pulse on a framing violation.

## Operation
- Flit type is `data[DATA_SIZE+1:DATA_SIZE]`:
  - 2'b01 head
  - 2'b00 body
  - 2'b10 tail
  - 2'b11 single (head+tail)
- Payload is `data[DATA_SIZE-1:0]`. A head's low bits carry the destination address; the buffer does not interpret them.
- Input accept occurs on a rising edge with `in_w && in_r`.
- Output transfer occurs on a rising edge with `out_w && out_r`.
- `in_r = (count != DEPTH)`. It is combinational from registered state only and never depends on `out_r` or `in_w`.
- `out_w = (count != 0)`. `data_o = mem[rd_ptr]` (first-word fall-through). `data_o` is held stable while `out_w` is high and `out_r` is low.
- Framing FSM on accepted flits, with states IDLE and IN_PKT:
  - IDLE + head → store, go to IN_PKT.
  - IDLE + single → store, stay IDLE.
  - IDLE + body/tail → discard (not stored, `count` unchanged), pulse `err`.
  - IN_PKT + body → store, stay.
  - IN_PKT + tail → store, go to IDLE.
  - IN_PKT + head → store, pulse `err`, stay IN_PKT (new packet begins).
  - IN_PKT + single → store, pulse `err`, go to IDLE.
- Discarded flits still consume the handshake, so upstream sees them accepted.
- `rd_ptr`/`wr_ptr` are log2(DEPTH) bits and wrap modulo DEPTH.
- `count` is computed as: +1 on a stored write, −1 on a read, unchanged on both or neither.

## Timing
- Reset (asynchronous assert, synchronous-clean release):
  - `rd_ptr = wr_ptr = 0`, `count = 0`, FSM in IDLE, `err = 0`.
  - Hence `out_w = 0`, `in_r = 1`.
  - `data_o` is don't-care (mem is not reset).
- Latency is one cycle: a flit stored at edge N appears on `data_o` with `out_w = 1` after edge N, provided the FIFO was empty.
- Full and simultaneous read: `in_r = 0` that cycle even if `out_r = 1`. The write is refused and `in_r` rises the cycle after the read.
- Empty and simultaneous write: no bypass. The read cannot occur because `out_w = 0`, and the flit is visible next cycle.
- Read and write in the same cycle with 0 < count < DEPTH: both happen and `count` is unchanged.
- Throughput is one flit per cycle sustained when `out_r` is held high.
- `err` is registered. It is high for exactly the cycle following the offending accept edge.
- Reset mid-packet: contents are lost and the FSM returns to IDLE. The next body/tail after reset is an orphan.

## Test plan
- **Pass-through:** after reset, with `out_r = 1`, send single 6'b11_0001, then head 6'b01_0000, body 6'b00_1010, tail 6'b10_0101 on consecutive cycles. Required: `data_o` shows the same four flits in order, each one cycle after acceptance; `err` stays 0; `count` ≤ 1.
- **Fill/full:** DEPTH=4, `out_r = 0`, send head + 3 bodies. Required: `count` = 4, `in_r = 0`, a fifth `in_w` is not accepted. Then raise `out_r` for one cycle: `count` = 3, and `in_r = 1` the next cycle.
- **Orphan drop:** in IDLE, send body 6'b00_0110 then tail 6'b10_0011. Required: two `err` pulses, `count` stays 0, `out_w` stays 0.
- **Head inside packet:** send head, body, head, tail. Required: one `err` pulse after the second head; all 4 flits are output in order.
- **Wrap-around:** stream 20 flits (head, 18 bodies, tail) with `out_r` toggling 1,0,1,0. Required: in-order output, no loss or duplication, pointers wrap correctly, `count` never exceeds 4.
- **Reset mid-packet:** with 3 flits buffered, assert `a_rst` between edges. Required: `out_w` and `count` go to 0 immediately; after release, a body input produces `err` and is dropped.

Source files
------------

// File: rtl/flit_buffer.sv
// flit_buffer
// Elastic flit FIFO between a traffic node's output and the next hop's input.
// Both sides use the same write/ready handshake. Well-formed packets pass
// through in order. Orphan body/tail flits are accepted but discarded, and
// err is flagged for them.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   a_rst  - asynchronous active-high reset
//   data_i - incoming flit {type[1:0], payload[DATA_SIZE-1:0]}
//   in_w   - upstream presents a valid flit
//   in_r   - buffer can accept a flit this cycle (depends only on stored state)
//   data_o - head-of-FIFO flit (first-word fall-through)
//   out_w  - data_o valid
//   out_r  - downstream accepts this cycle
//   count  - number of stored flits
//   err    - one-cycle pulse after an accepted flit that breaks framing
module flit_buffer #(
  parameter int DATA_SIZE = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic [DATA_SIZE+1:0] data_i,
  input  logic                 in_w,
  output logic                 in_r,
  output logic [DATA_SIZE+1:0] data_o,
  output logic                 out_w,
  input  logic                 out_r,
  output logic [CNT_W-1:0]     count,
  output logic                 err
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic [DATA_SIZE+1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_err;
  state_t               r_state;

  logic       w_accept;
  logic       w_write;
  logic       w_read;
  logic       w_err;
  logic [1:0] w_type;
  state_t     w_next_state;

  assign in_r   = (r_count != CNT_W'(DEPTH));
  assign out_w  = (r_count != '0);
  assign data_o = r_mem[r_rd_ptr];
  assign count  = r_count;
  assign err    = r_err;

  assign w_accept = in_w && in_r;
  assign w_read   = out_w && out_r;
  assign w_type   = data_i[DATA_SIZE+1:DATA_SIZE];

  // Framing checker: decides whether an accepted flit is stored and whether
  // it breaks packet framing. A head or single arriving inside a packet is
  // still stored, because it legitimately starts new traffic.
  always_comb begin
    w_write      = 1'b0;
    w_err        = 1'b0;
    w_next_state = r_state;
    if (w_accept) begin
      unique case (r_state)
        IDLE: begin
          unique case (w_type)
            T_HEAD: begin
              w_write      = 1'b1;
              w_next_state = IN_PKT;
            end
            T_SINGLE: w_write = 1'b1;
            default:  w_err   = 1'b1;
          endcase
        end
        IN_PKT: begin
          w_write = 1'b1;
          unique case (w_type)
            T_BODY: w_next_state = IN_PKT;
            T_TAIL: w_next_state = IDLE;
            T_HEAD: w_err        = 1'b1;
            default: begin
              w_err        = 1'b1;
              w_next_state = IDLE;
            end
          endcase
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Pointers, occupancy, framing state and the registered error pulse.
  // Pointers are log2(DEPTH) wide, so they wrap naturally.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_state  <= IDLE;
      r_err    <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_read)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_write, w_read})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_state <= w_next_state;
      r_err   <= w_err;
    end
  end

  // Storage array is deliberately not reset; data_o is don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= data_i;
  end

endmodule
